clk_div_bank: RTL and testbench

Multi-channel programmable clock divider: a parametrised bank of `NCH` independent divider channels, all driven from the single 50 MHz system clock. Each channel has its own time constant, enable and output mode (square wave or one-cycle pulse), plus a per-cycle tick strobe. Time-constant updates are double-buffered so a channel never produces a runt period. A global `sync` realigns all channels. It replaces single-channel dividers wherever several derived rates are needed, such as sample clocks, echo delay taps and display scan.

---
 rtl/clk_div_pkg.sv | 7 +
 rtl/clk_div_chan.sv | 88 ++++++++
 rtl/clk_div_bank.sv | 38 +++
 tb/tb_clk_div_bank.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants for the multi-channel clock divider bank.
package clk_div_pkg;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: down-counter with double-buffered time constant,
// square/pulse output modes and a terminal-count tick.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int BIT_SZ = 21
) (
    input  logic              clkin,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic              load,
    input  logic              sync,
    input  logic [BIT_SZ-1:0] tc,
    output logic              clkout,
    output logic              tick
);

    localparam logic [BIT_SZ-1:0] CTR_ONE = {{(BIT_SZ-1){1'b0}}, 1'b1};

    logic [BIT_SZ-1:0] ctr_reg, ctr_next;
    logic [BIT_SZ-1:0] tc_act_reg, tc_act_next;
    logic [BIT_SZ-1:0] tc_sh_reg, tc_sh_next;
    logic              pend_reg, pend_next;
    logic              clkout_reg, clkout_next;
    logic              tick_reg, tick_next;

    always_comb begin
        ctr_next    = ctr_reg;
        tc_act_next = tc_act_reg;
        tc_sh_next  = tc_sh_reg;
        pend_next   = pend_reg;
        clkout_next = clkout_reg;
        tick_next   = 1'b0;

        if (sync) begin
            ctr_next    = '0;
            clkout_next = 1'b0;
        end else if (en) begin
            if (ctr_reg == '0) begin
                // Commit uses the pre-edge shadow, so a same-cycle load stays pending.
                if (pend_reg) begin
                    ctr_next    = tc_sh_reg;
                    tc_act_next = tc_sh_reg;
                    pend_next   = 1'b0;
                end else begin
                    ctr_next = tc_act_reg;
                end
                tick_next   = 1'b1;
                clkout_next = (mode == MODE_PULSE) ? 1'b1 : ~clkout_reg;
            end else begin
                ctr_next = ctr_reg - CTR_ONE;
                if (mode == MODE_PULSE) begin
                    clkout_next = 1'b0;
                end
            end
        end else if (mode == MODE_PULSE) begin
            clkout_next = 1'b0;
        end

        if (load) begin
            tc_sh_next = tc;
            pend_next  = 1'b1;
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            ctr_reg    <= '0;
            tc_act_reg <= '0;
            tc_sh_reg  <= '0;
            pend_reg   <= 1'b0;
            clkout_reg <= 1'b0;
            tick_reg   <= 1'b0;
        end else begin
            ctr_reg    <= ctr_next;
            tc_act_reg <= tc_act_next;
            tc_sh_reg  <= tc_sh_next;
            pend_reg   <= pend_next;
            clkout_reg <= clkout_next;
            tick_reg   <= tick_next;
        end
    end

    assign clkout = clkout_reg;
    assign tick   = tick_reg;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NCH independent programmable clock dividers sharing one clock
// and a global realign strobe.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int BIT_SZ = 21,
    parameter int NCH    = 4
) (
    input  logic                  clkin,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        en,
    input  logic [NCH-1:0]        mode,
    input  logic [NCH*BIT_SZ-1:0] tc_bus,
    input  logic [NCH-1:0]        load,
    input  logic                  sync,
    output logic [NCH-1:0]        clkout,
    output logic [NCH-1:0]        tick
);

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            clk_div_chan #(
                .BIT_SZ (BIT_SZ)
            ) u_chan (
                .clkin  (clkin),
                .rst_n  (rst_n),
                .en     (en[gi]),
                .mode   (mode[gi]),
                .load   (load[gi]),
                .sync   (sync),
                .tc     (tc_bus[gi*BIT_SZ +: BIT_SZ]),
                .clkout (clkout[gi]),
                .tick   (tick[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// Randomised scoreboard bench for clk_div_bank with a behavioural
// per-channel period model.
module tb_clk_div_bank;

    localparam int BIT_SZ = 21;
    localparam int NCH    = 4;

    logic                  clkin = 1'b0;
    logic                  rst_n;
    logic [NCH-1:0]        en;
    logic [NCH-1:0]        mode;
    logic [NCH*BIT_SZ-1:0] tc_bus;
    logic [NCH-1:0]        load;
    logic                  sync;
    logic [NCH-1:0]        clkout;
    logic [NCH-1:0]        tick;

    always #10 clkin = ~clkin;

    clk_div_bank #(
        .BIT_SZ (BIT_SZ),
        .NCH    (NCH)
    ) dut (
        .clkin  (clkin),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode),
        .tc_bus (tc_bus),
        .load   (load),
        .sync   (sync),
        .clkout (clkout),
        .tick   (tick)
    );

    typedef struct packed {
        logic [NCH-1:0] clk;
        logic [NCH-1:0] tk;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    // Reference: each channel is "left" enabled cycles away from its next
    // terminal count, with a period length and an optional queued new period.
    int unsigned m_left[NCH];
    int unsigned m_period[NCH];
    int unsigned m_queued[NCH];
    bit          m_has_queued[NCH];
    bit          m_level[NCH];

    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_left[i]       = 0;
            m_period[i]     = 0;
            m_queued[i]     = 0;
            m_has_queued[i] = 0;
            m_level[i]      = 0;
        end
    endfunction

    function automatic void model_step();
        exp_t e;
        e = '0;
        for (int i = 0; i < NCH; i++) begin
            bit fire;
            fire = 0;
            if (sync) begin
                m_left[i]  = 0;
                m_level[i] = 0;
            end else if (en[i]) begin
                if (m_left[i] == 0) begin
                    fire = 1;
                    if (m_has_queued[i]) begin
                        m_period[i]     = m_queued[i];
                        m_has_queued[i] = 0;
                    end
                    m_left[i]  = m_period[i];
                    m_level[i] = mode[i] ? 1'b1 : ~m_level[i];
                end else begin
                    m_left[i] = m_left[i] - 1;
                    if (mode[i]) m_level[i] = 0;
                end
            end else if (mode[i]) begin
                m_level[i] = 0;
            end
            if (load[i]) begin
                m_queued[i]     = int'(tc_bus[i*BIT_SZ +: BIT_SZ]);
                m_has_queued[i] = 1;
            end
            e.clk[i] = m_level[i];
            e.tk[i]  = fire;
        end
        exp_q.push_back(e);
    endfunction

    function automatic void set_tc(int ch, int unsigned v);
        tc_bus[ch*BIT_SZ +: BIT_SZ] = v[BIT_SZ-1:0];
    endfunction

    // Inputs change 2 time units after a rising edge; strobes last one cycle.
    task automatic drive(int n);
        repeat (n) begin
            model_step();
            @(posedge clkin);
            #2;
            cyc++;
            load = '0;
            sync = 1'b0;
        end
    endtask

    task automatic check_zero(string name);
        vectors++;
        if (clkout !== '0 || tick !== '0) begin
            miscompares++;
            $display("FAIL %s: clkout=%b tick=%b, required clkout=0 tick=0", name, clkout, tick);
        end
    endtask

    task automatic mid_reset();
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(posedge clkin);
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: every edge, compare the DUT against the oldest queued expectation.
    initial begin
        forever begin
            @(posedge clkin);
            #1;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                vectors++;
                if (clkout !== e.clk || tick !== e.tk) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t: clkout=%b tick=%b, required clkout=%b tick=%b",
                             $time, clkout, tick, e.clk, e.tk);
                end
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        en     = '0;
        mode   = '0;
        tc_bus = '0;
        load   = '0;
        sync   = 1'b0;
        model_reset();
        repeat (3) @(posedge clkin);
        #2;
        check_zero("reset_state");
        rst_n = 1'b1;

        // ch0 square tc=4; ch1 pulse with reset tc_act=0
        set_tc(0, 4);
        load[0] = 1'b1;
        drive(1);
        mode[1] = 1'b1;
        en[0]   = 1'b1;
        en[1]   = 1'b1;
        drive(24);
        set_tc(1, 2);
        load[1] = 1'b1;
        drive(12);

        // ch2: two loads inside one period, last one wins
        set_tc(2, 6);
        load[2] = 1'b1;
        en[2]   = 1'b1;
        drive(4);
        set_tc(2, 9);
        load[2] = 1'b1;
        drive(2);
        set_tc(2, 3);
        load[2] = 1'b1;
        drive(20);

        // ch3: enable gap mid-count
        set_tc(3, 5);
        load[3] = 1'b1;
        en[3]   = 1'b1;
        drive(9);
        en[3] = 1'b0;
        drive(7);
        en[3] = 1'b1;
        drive(12);

        // all channels square, then realign
        mode = '0;
        set_tc(0, 3);
        set_tc(1, 5);
        set_tc(2, 6);
        set_tc(3, 8);
        load = '1;
        drive(30);
        sync = 1'b1;
        drive(12);

        // reset with a pending load, then fclk/2 from the cleared tc
        set_tc(0, 7);
        load[0] = 1'b1;
        drive(1);
        mid_reset();
        en   = '1;
        mode = '0;
        drive(8);

        // randomised phase
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 7) == 0)  en[i]   = ~en[i];
                if ($urandom_range(0, 63) == 0) mode[i] = ~mode[i];
                if ($urandom_range(0, 15) == 0) begin
                    set_tc(i, $urandom_range(0, 10));
                    load[i] = 1'b1;
                end
            end
            if ($urandom_range(0, 99) == 0) sync = 1'b1;
            if ($urandom_range(0, 499) == 0) begin
                load = '0;
                sync = 1'b0;
                mid_reset();
            end else begin
                drive(1);
            end
        end

        @(posedge clkin);
        #3;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
